// File: rtl/dbg_router.sv
// Debug-bus router: host port to NUM_SEG segments, segment 0 is the internal control register file.
// Optional statistics counters are compiled in with `define DBG_ROUTER_STATS_EN.
module dbg_router #(
  parameter int NUM_SEG = 4,
  parameter int SEG_W   = 2,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 8,
  parameter int NUM_RST = 3,
  parameter int TIMEOUT = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(8'hEE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEG_W+ADDR_W-1:0]   dbg_addr_i,
  input  logic                      dbg_wen_i,
  input  logic                      dbg_ren_i,
  input  logic [DATA_W-1:0]         dbg_wdata_i,
  output logic [DATA_W-1:0]         dbg_rdata_o,
  output logic                      dbg_rdata_vld_o,
  output logic                      dbg_busy_o,
  output logic [ADDR_W-1:0]         tgt_addr_o,
  output logic [DATA_W-1:0]         tgt_wdata_o,
  output logic [NUM_SEG-1:0]        tgt_wen_o,
  output logic [NUM_SEG-1:0]        tgt_ren_o,
  input  logic [NUM_SEG*DATA_W-1:0] tgt_rdata_i,
  input  logic [NUM_SEG-1:0]        tgt_rdata_vld_i,
  output logic [NUM_RST-1:0]        sys_rst_o,
  output logic                      dbg_err_o,
  output logic [2:0]                state_o
);
  // Handshake: dbg_wen_i/dbg_ren_i are single-cycle strobes accepted only while dbg_busy_o is low;
  // each accepted read yields exactly one dbg_rdata_vld_o pulse, targets answer with one tgt_rdata_vld_i pulse.
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CTL, S_UNMAP, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [SEG_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_RST-1:0]  sys_rst_q, sys_rst_d;
  logic [2:0]          status_q, status_d, status_set, status_clr;
  logic [DATA_W-1:0]   sel_rdata, ctl_rdata;
  logic                sel_vld, idle, seg_unmapped, ctl_wr;
  logic [SEG_W-1:0]    seg;
  logic [ADDR_W-1:0]   in_addr;

  assign seg          = dbg_addr_i[SEG_W+ADDR_W-1 -: SEG_W];
  assign in_addr      = dbg_addr_i[ADDR_W-1:0];
  assign idle         = (state_q == S_IDLE);
  assign seg_unmapped = (int'(seg) >= NUM_SEG);
  assign ctl_wr       = idle && dbg_wen_i && (seg == '0);

`ifdef DBG_ROUTER_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d, err_cnt_q, err_cnt_d;
`endif

  always_comb begin
    tgt_wen_o = '0;
    tgt_ren_o = '0;
    for (int s = 1; s < NUM_SEG; s++) begin
      tgt_wen_o[s] = dbg_wen_i && idle && (seg == SEG_W'(s));
      tgt_ren_o[s] = dbg_ren_i && idle && (seg == SEG_W'(s));
    end
  end

  always_comb begin
    sel_rdata = '0;
    sel_vld   = 1'b0;
    for (int s = 0; s < NUM_SEG; s++) begin
      if (sel_q == SEG_W'(s)) begin
        sel_rdata = tgt_rdata_i[s*DATA_W +: DATA_W];
        sel_vld   = tgt_rdata_vld_i[s];
      end
    end
  end

  always_comb begin
    ctl_rdata = DATA_W'(8'hAA);
    case (addr_q)
      ADDR_W'(0): ctl_rdata = DATA_W'(sys_rst_q);
      ADDR_W'(1): ctl_rdata = DATA_W'(status_q);
      ADDR_W'(2): ctl_rdata = DATA_W'(TIMEOUT);
      ADDR_W'(3): ctl_rdata = DATA_W'(NUM_SEG);
`ifdef DBG_ROUTER_STATS_EN
      ADDR_W'(4): ctl_rdata = DATA_W'(rd_cnt_q[7:0]);
      ADDR_W'(5): ctl_rdata = DATA_W'(rd_cnt_q[15:8]);
      ADDR_W'(6): ctl_rdata = DATA_W'(err_cnt_q[7:0]);
      ADDR_W'(7): ctl_rdata = DATA_W'(err_cnt_q[15:8]);
`endif
      default:    ctl_rdata = DATA_W'(8'hAA);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    status_set = '0;
    case (state_q)
      S_IDLE: begin
        if (dbg_ren_i) begin
          sel_d   = seg;
          addr_d  = in_addr;
          timer_d = TMR_W'(1);
          if (seg == '0)        state_d = S_CTL;
          else if (seg_unmapped) state_d = S_UNMAP;
          else                   state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sel_vld) begin
          rdata_d = sel_rdata;
          state_d = S_RESP;
        end else if ((TIMEOUT != 0) && (timer_q == TMR_W'(TIMEOUT))) begin
          rdata_d       = ERR_DATA;
          status_set[0] = 1'b1;
          state_d       = S_RESP;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_CTL: begin
        rdata_d = ctl_rdata;
        state_d = S_RESP;
      end
      S_UNMAP: begin
        rdata_d       = ERR_DATA;
        status_set[1] = 1'b1;
        state_d       = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!idle && (dbg_wen_i || dbg_ren_i)) status_set[2] = 1'b1;
    if (idle && dbg_wen_i && seg_unmapped) status_set[1] = 1'b1;
  end

  // Status is write-1-to-clear; a set in the same cycle wins over the clear.
  always_comb begin
    sys_rst_d  = sys_rst_q;
    status_clr = '0;
    if (ctl_wr && (in_addr == ADDR_W'(0))) sys_rst_d  = dbg_wdata_i[NUM_RST-1:0];
    if (ctl_wr && (in_addr == ADDR_W'(1))) status_clr = dbg_wdata_i[2:0];
    status_d = (status_q & ~status_clr) | status_set;
  end

`ifdef DBG_ROUTER_STATS_EN
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    if ((state_d == S_RESP) && (state_q != S_RESP)) rd_cnt_d = rd_cnt_q + 16'd1;
    if (status_set[0] || (state_q == S_UNMAP))       err_cnt_d = err_cnt_q + 16'd1;
    if (ctl_wr && (in_addr == ADDR_W'(4))) begin
      rd_cnt_d  = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      sel_q     <= '0;
      addr_q    <= '0;
      rdata_q   <= '0;
      sys_rst_q <= '1;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      sys_rst_q <= sys_rst_d;
      status_q  <= status_d;
    end
  end

  assign dbg_rdata_o     = rdata_q;
  assign dbg_rdata_vld_o = (state_q == S_RESP);
  assign dbg_busy_o      = !idle;
  assign tgt_addr_o      = in_addr;
  assign tgt_wdata_o     = dbg_wdata_i;
  assign sys_rst_o       = sys_rst_q;
  assign dbg_err_o       = |status_q;
  assign state_o         = state_q;
endmodule

// File: tb/tb_dbg_router.sv
// Directed bench for dbg_router built with NUM_SEG=3 so segment 3 is unmapped.
module tb_dbg_router;
  localparam int NUM_SEG = 3;
  localparam int SEG_W   = 2;
  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 8;
  localparam int NUM_RST = 3;
  localparam int TIMEOUT = 15;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [SEG_W+ADDR_W-1:0]   dbg_addr;
  logic                      dbg_wen, dbg_ren;
  logic [DATA_W-1:0]         dbg_wdata, dbg_rdata;
  logic                      dbg_rdata_vld, dbg_busy;
  logic [ADDR_W-1:0]         tgt_addr;
  logic [DATA_W-1:0]         tgt_wdata;
  logic [NUM_SEG-1:0]        tgt_wen, tgt_ren;
  logic [NUM_SEG*DATA_W-1:0] tgt_rdata;
  logic [NUM_SEG-1:0]        tgt_rdata_vld;
  logic [NUM_RST-1:0]        sys_rst;
  logic                      dbg_err;
  logic [2:0]                state;

  int checks = 0;
  int errors = 0;

  dbg_router #(.NUM_SEG(NUM_SEG), .SEG_W(SEG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
               .NUM_RST(NUM_RST), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .dbg_addr_i(dbg_addr), .dbg_wen_i(dbg_wen), .dbg_ren_i(dbg_ren), .dbg_wdata_i(dbg_wdata),
    .dbg_rdata_o(dbg_rdata), .dbg_rdata_vld_o(dbg_rdata_vld), .dbg_busy_o(dbg_busy),
    .tgt_addr_o(tgt_addr), .tgt_wdata_o(tgt_wdata), .tgt_wen_o(tgt_wen), .tgt_ren_o(tgt_ren),
    .tgt_rdata_i(tgt_rdata), .tgt_rdata_vld_i(tgt_rdata_vld),
    .sys_rst_o(sys_rst), .dbg_err_o(dbg_err), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; dbg_wen = 1'b0; dbg_ren = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    tgt_rdata = '0; tgt_rdata_vld = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] mk(input logic [1:0] sg, input logic [13:0] a);
    return {sg, a};
  endfunction

  task automatic do_write(input logic [15:0] addr, input logic [7:0] wd);
    dbg_wen = 1'b1; dbg_addr = addr; dbg_wdata = wd;
    cyc();
    dbg_wen = 1'b0;
  endtask

  // Strobes a read (optionally with a write), answers from the target after 'delay' cycles
  // (-1 = never) and returns the data, the latency from strobe to vld and the tgt_ren seen.
  task automatic read_txn(input logic [15:0] addr, input int delay, input logic [7:0] tdata,
                          input logic with_wen, input logic [7:0] wd,
                          output logic [7:0] data, output int lat, output logic [2:0] ren_seen);
    int sg;
    sg = int'(addr[15:14]);
    dbg_ren = 1'b1; dbg_wen = with_wen; dbg_wdata = wd; dbg_addr = addr;
    if (sg < NUM_SEG) tgt_rdata[sg*8 +: 8] = tdata;
    #1 ren_seen = tgt_ren;
    cyc();
    dbg_ren = 1'b0; dbg_wen = 1'b0;
    lat = 0; data = '0;
    for (int k = 1; k <= 40; k++) begin
      tgt_rdata_vld = '0;
      if (dbg_rdata_vld === 1'b1) begin
        lat = k; data = dbg_rdata;
        break;
      end
      checks++;
      if (dbg_busy !== 1'b1) begin
        errors++; $display("FAIL busy_during_read: got %b want 1 (cycle %0d)", dbg_busy, k);
      end
      if (k == delay && sg < NUM_SEG) tgt_rdata_vld[sg] = 1'b1;
      cyc();
    end
    checks++;
    if (lat == 0) begin
      errors++; $display("FAIL read_response_timeout: no dbg_rdata_vld within 40 cycles");
    end
    tgt_rdata_vld = '0;
    cyc();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (sys_rst !== 3'b111) begin errors++; $display("FAIL reset_sys_rst: got %b want 111", sys_rst); end
    checks++; if (dbg_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", dbg_rdata); end
    checks++; if (dbg_rdata_vld !== 1'b0 || dbg_busy !== 1'b0 || dbg_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: vld=%b busy=%b err=%b want 0 0 0", dbg_rdata_vld, dbg_busy, dbg_err); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
  endtask

  task automatic test_ctl();
    logic [7:0] d; int lat; logic [2:0] rs;
    read_txn(mk(2'd0, 14'd0), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'h07 || lat != 2) begin errors++; $display("FAIL ctl0_read: got %h lat %0d want 07 lat 2", d, lat); end
    checks++; if (rs !== 3'b000) begin errors++; $display("FAIL ctl_no_tgt_ren: got %b want 000", rs); end
    dbg_wen = 1'b1; dbg_addr = mk(2'd0, 14'd0); dbg_wdata = 8'h00;
    #1;
    checks++; if (tgt_wen !== 3'b000) begin errors++; $display("FAIL ctl_no_tgt_wen: got %b want 000", tgt_wen); end
    cyc(); dbg_wen = 1'b0;
    checks++; if (sys_rst !== 3'b000) begin errors++; $display("FAIL ctl0_write: got %b want 000", sys_rst); end
    read_txn(mk(2'd0, 14'd2), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'h0F) begin errors++; $display("FAIL ctl2_timeout: got %h want 0F", d); end
    read_txn(mk(2'd0, 14'd3), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL ctl3_numseg: got %h want 03", d); end
    read_txn(mk(2'd0, 14'd9), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'hAA) begin errors++; $display("FAIL ctl9_default: got %h want AA", d); end
    read_txn(mk(2'd0, 14'd0), -1, 8'h00, 1'b1, 8'h05, d, lat, rs);
    checks++; if (d !== 8'h05 || sys_rst !== 3'b101) begin
      errors++; $display("FAIL ctl_wen_ren: got %h sys_rst %b want 05 101", d, sys_rst); end
  endtask

  task automatic test_ext_read();
    logic [7:0] d; int lat; logic [2:0] rs;
    read_txn(mk(2'd1, 14'd5), 3, 8'h5A, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'h5A || lat != 4) begin errors++; $display("FAIL seg1_read: got %h lat %0d want 5A lat 4", d, lat); end
    checks++; if (rs !== 3'b010) begin errors++; $display("FAIL seg1_tgt_ren: got %b want 010", rs); end
    dbg_wen = 1'b1; dbg_addr = mk(2'd2, 14'h123); dbg_wdata = 8'h3C;
    #1;
    checks++; if (tgt_wen !== 3'b100 || tgt_ren !== 3'b000 || tgt_addr !== 14'h123 || tgt_wdata !== 8'h3C) begin
      errors++; $display("FAIL seg2_write: wen %b ren %b addr %h wdata %h want 100 000 0123 3C",
                         tgt_wen, tgt_ren, tgt_addr, tgt_wdata); end
    cyc(); dbg_wen = 1'b0;
  endtask

  task automatic test_timeout();
    logic [7:0] d; int lat; logic [2:0] rs;
    read_txn(mk(2'd2, 14'd1), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'hEE || lat != TIMEOUT + 1) begin
      errors++; $display("FAIL timeout_read: got %h lat %0d want EE lat %0d", d, lat, TIMEOUT + 1); end
    checks++; if (dbg_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", dbg_err); end
    tgt_rdata_vld[2] = 1'b1;
    cyc(); tgt_rdata_vld = '0;
    checks++; if (dbg_rdata_vld !== 1'b0 || dbg_busy !== 1'b0) begin
      errors++; $display("FAIL late_vld: vld %b busy %b want 0 0", dbg_rdata_vld, dbg_busy); end
    read_txn(mk(2'd0, 14'd1), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL timeout_status: got %h want 01", d); end
    do_write(mk(2'd0, 14'd1), 8'h01);
    read_txn(mk(2'd0, 14'd1), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'h00 || dbg_err !== 1'b0) begin
      errors++; $display("FAIL status_clear: got %h err %b want 00 0", d, dbg_err); end
  endtask

  task automatic test_busy_drop();
    logic [7:0] d; int lat; logic [2:0] rs;
    dbg_ren = 1'b1; dbg_addr = mk(2'd1, 14'd7);
    cyc();
    dbg_addr = mk(2'd2, 14'd7);
    #1;
    checks++; if (tgt_ren !== 3'b000) begin errors++; $display("FAIL busy_no_ren: got %b want 000", tgt_ren); end
    cyc();
    dbg_ren = 1'b0; tgt_rdata[15:8] = 8'h77; tgt_rdata_vld[1] = 1'b1;
    cyc();
    tgt_rdata_vld = '0;
    checks++; if (dbg_rdata_vld !== 1'b1 || dbg_rdata !== 8'h77) begin
      errors++; $display("FAIL busy_pending_read: vld %b data %h want 1 77", dbg_rdata_vld, dbg_rdata); end
    cyc();
    read_txn(mk(2'd0, 14'd1), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'h04 || dbg_err !== 1'b1) begin
      errors++; $display("FAIL busy_status: got %h err %b want 04 1", d, dbg_err); end
    do_write(mk(2'd0, 14'd1), 8'h04);
  endtask

  task automatic test_unmap();
    logic [7:0] d; int lat; logic [2:0] rs;
    read_txn(mk(2'd3, 14'd0), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'hEE || lat != 2) begin errors++; $display("FAIL unmap_read: got %h lat %0d want EE lat 2", d, lat); end
    read_txn(mk(2'd0, 14'd1), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL unmap_status: got %h want 02", d); end
    do_write(mk(2'd0, 14'd1), 8'h02);
    dbg_wen = 1'b1; dbg_addr = mk(2'd3, 14'd4); dbg_wdata = 8'h11;
    #1;
    checks++; if (tgt_wen !== 3'b000) begin errors++; $display("FAIL unmap_write_wen: got %b want 000", tgt_wen); end
    cyc(); dbg_wen = 1'b0;
    read_txn(mk(2'd0, 14'd1), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL unmap_write_status: got %h want 02", d); end
    do_write(mk(2'd0, 14'd1), 8'h07);
    checks++; if (dbg_err !== 1'b0) begin errors++; $display("FAIL unmap_clear: err %b want 0", dbg_err); end
  endtask

  task automatic test_rst_mid_read();
    logic [7:0] d; int lat; logic [2:0] rs; int seen;
    do_write(mk(2'd0, 14'd0), 8'h00);
    dbg_ren = 1'b1; dbg_addr = mk(2'd1, 14'd3);
    cyc(); dbg_ren = 1'b0;
    cyc();
    rst = 1'b1;
    cyc(); rst = 1'b0;
    checks++; if (state !== 3'd0 || sys_rst !== 3'b111 || dbg_busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_read: state %0d sys_rst %b busy %b want 0 111 0", state, sys_rst, dbg_busy); end
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      tgt_rdata_vld[1] = (k == 1);
      if (dbg_rdata_vld === 1'b1) seen++;
      cyc();
    end
    tgt_rdata_vld = '0;
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_no_vld: got %0d pulses want 0", seen); end
    read_txn(mk(2'd1, 14'd3), 2, 8'hA5, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'hA5 || lat != 3) begin errors++; $display("FAIL rst_next_read: got %h lat %0d want A5 lat 3", d, lat); end
  endtask

  task automatic test_stats();
    logic [7:0] d; int lat; logic [2:0] rs;
    apply_reset();
`ifdef DBG_ROUTER_STATS_EN
    for (int i = 0; i < 3; i++) read_txn(mk(2'd1, 14'(i)), 1, 8'(i), 1'b0, 8'h00, d, lat, rs);
    read_txn(mk(2'd2, 14'd0), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    read_txn(mk(2'd0, 14'd4), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL stats_rd_lo: got %h want 04", d); end
    read_txn(mk(2'd0, 14'd5), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL stats_rd_hi: got %h want 00", d); end
    read_txn(mk(2'd0, 14'd6), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL stats_err_lo: got %h want 01", d); end
    do_write(mk(2'd0, 14'd4), 8'h00);
    read_txn(mk(2'd0, 14'd4), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL stats_clear_rd: got %h want 00", d); end
    read_txn(mk(2'd0, 14'd6), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL stats_clear_err: got %h want 00", d); end
`else
    read_txn(mk(2'd0, 14'd4), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'hAA) begin errors++; $display("FAIL nostats_ctl4: got %h want AA", d); end
    read_txn(mk(2'd0, 14'd7), -1, 8'h00, 1'b0, 8'h00, d, lat, rs);
    checks++; if (d !== 8'hAA) begin errors++; $display("FAIL nostats_ctl7: got %h want AA", d); end
`endif
  endtask

  initial begin
    rst = 1'b1; dbg_wen = 1'b0; dbg_ren = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    tgt_rdata = '0; tgt_rdata_vld = '0;
    test_reset();
    test_ctl();
    test_ext_read();
    test_timeout();
    test_busy_drop();
    test_unmap();
    test_rst_mid_read();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
